ula_seq: RTL
============

Name: ula_seq

Overview:
- Parametrised-width sequential ALU; successor to the team's 4-bit combinational CLA ALU.
- Operands and opcode are latched on a start/done handshake. Result, status flags and the group P/G terms for cascading the CLA are registered.
- Adds XOR, shifts and a multi-cycle shift-add unsigned multiply.
- Sits between the register file and the writeback mux of the datapath.

Parameters:
- WIDTH, 8, operand/result width; power of two, >= 4.
- SHW, $clog2(WIDTH), derived; number of B bits used as the shift amount.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- seletor  input  4  opcode
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- cin  input  1  carry-in (ADD only)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; result/flags valid from this cycle
- resultado  output  WIDTH  result (low half for MUL)
- resultado_hi  output  WIDTH  high half of MUL product; 0 for other ops
- Z, N, C, V  output  1 each  zero, negative, carry, signed-overflow flags
- P_out, G_out  output  1 each  group propagate/generate of the latched add operands

Behaviour:
- Clock/reset: one clock (clk). Reset is synchronous and active-high (rst). On rst, all outputs and internal state are 0 and the FSM goes to IDLE. rst overrides start. rst mid-MUL aborts with no done pulse.
- FSM states: IDLE, EXEC, MUL, DONE.
- IDLE, start=1: latch A, B, cin, seletor. Opcode 1010 -> MUL with counter=0; otherwise -> EXEC.
- EXEC (1 cycle): compute and register outputs -> DONE.
- MUL: each cycle, if multiplier LSB=1 add the shifted multiplicand into a 2*WIDTH accumulator. Counter increments; after WIDTH cycles -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE. busy=1 in EXEC, MUL and DONE.
- Latency: start seen at edge k. Single-cycle ops assert done in cycle k+2. MUL asserts done in cycle k+WIDTH+2.
- Back-to-back: start may be asserted in the cycle after done is seen; it is sampled in IDLE.
- start while busy=1 is ignored, and latched operands do not change.
- Outputs hold their last value until the next operation's done. Input changes after latching have no effect.
- Opcodes:
  - 0000 A&B
  - 0001 A|B
  - 0010 ~A
  - 0011 ~(A&B)
  - 0100 A+B+cin
  - 0101 A-B (A+~B+1; cin ignored)
  - 0110 A^B
  - 0111 A<<B[SHW-1:0]
  - 1000 A>>B[SHW-1:0] logical
  - 1001 A>>>B[SHW-1:0] arithmetic
  - 1010 unsigned A*B, {resultado_hi,resultado}
  - others resultado=0, all flags 0 except Z=1
- Flags:
  - Z = (resultado==0). For MUL, Z=1 only if the full product is 0.
  - N = resultado[WIDTH-1].
  - ADD: C = carry out.
  - SUB: C = no-borrow (A>=B unsigned).
  - Shifts: C = last bit shifted out; 0 when shift amount is 0.
  - MUL: C = (resultado_hi!=0).
  - Logic ops: C=0.
  - V = signed overflow for ADD/SUB; 0 for all other ops.
- P/G:
  - ADD uses operands A,B; SUB uses A,~B.
  - P_out = AND over all bits of (A^Bop).
  - G_out = standard CLA group generate ripple, MSB-first, excluding cin.
  - For all other ops, P_out=G_out=0.
- Width rules: all arithmetic is modulo 2^WIDTH except the MUL product (2*WIDTH bits). The MUL accumulator never overflows.

Test Plan (WIDTH=8):
- ADD A=FF B=01 cin=0 -> resultado=00, C=1, Z=1, V=0, N=0, P_out=0, G_out=1; done in cycle k+2.
- ADD A=7F B=01 cin=0 -> 80, V=1, N=1, C=0. SUB A=05 B=07 -> FE, C=0, N=1, V=0. SUB A=07 B=05 -> 02, C=1.
- MUL A=FF B=FF -> resultado=01, resultado_hi=FE, C=1; busy for 10 cycles, done at k+10. MUL A=0F B=11 -> FF/00, C=0.
- SHL A=81 B=01 -> 02, C=1. SRA A=80 B=03 -> F0, C=0. SHR A=01 B=00 -> 01, C=0.
- Start MUL, pulse start with ADD at cycle k+3 -> ignored; MUL result correct, single done.
- Assert rst at cycle k+4 of a MUL -> next cycle all outputs 0, busy=0, no done. A following ADD 03+04 -> 07 at k'+2.

Source files
------------

// File: rtl/ula_if.sv
// Handshake and result bundle between the register-file side and the sequential ALU.
interface ula_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [3:0]       seletor;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] resultado;
    logic [WIDTH-1:0] resultado_hi;
    logic             Z;
    logic             N;
    logic             C;
    logic             V;
    logic             P_out;
    logic             G_out;

    modport master (
        output start, seletor, A, B, cin,
        input  busy, done, resultado, resultado_hi, Z, N, C, V, P_out, G_out
    );

    modport slave (
        input  start, seletor, A, B, cin,
        output busy, done, resultado, resultado_hi, Z, N, C, V, P_out, G_out
    );
endinterface

// File: rtl/ula_seq.sv
// Sequential ALU: latches operands on start, runs single-cycle ops or a shift-add multiply,
// and holds registered result, flags and CLA group P/G until the next done.
module ula_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic   clk,
    input logic   rst,
    ula_if.slave  bus
);
    localparam int CW = SHW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_NOT  = 4'b0010;
    localparam logic [3:0] OP_NAND = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_SHL  = 4'b0111;
    localparam logic [3:0] OP_SHR  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    // CLA group generate, rippled so the MSB term ends up outermost.
    function automatic logic group_gen(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] g);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            acc = g[i] | (p[i] & acc);
        end
        return acc;
    endfunction

    logic [1:0]         state_r;
    logic [3:0]         op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               cin_r;
    logic [CW-1:0]      cnt_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   res_r;
    logic [WIDTH-1:0]   hi_r;
    logic               z_r, n_r, c_r, v_r, p_r, g_r;

    logic [WIDTH-1:0]   bop_s;
    logic               cin_eff_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH-1:0]   prop_s;
    logic [WIDTH-1:0]   gen_s;
    logic               ovf_s;
    logic [SHW-1:0]     sh_s;
    logic [WIDTH:0]     shl_s;
    logic [WIDTH:0]     shr_s;
    logic [WIDTH:0]     sra_s;
    logic [WIDTH-1:0]   res_s;
    logic               c_s, v_s, p_s, g_s;

    // Subtraction reuses the adder as A + ~B + 1.
    assign bop_s     = (op_r == OP_SUB) ? ~b_r : b_r;
    assign cin_eff_s = (op_r == OP_SUB) ? 1'b1 : cin_r;
    assign sum_s     = {1'b0, a_r} + {1'b0, bop_s} + {{WIDTH{1'b0}}, cin_eff_s};
    assign prop_s    = a_r ^ bop_s;
    assign gen_s     = a_r & bop_s;
    assign ovf_s     = (a_r[WIDTH-1] == bop_s[WIDTH-1]) && (sum_s[WIDTH-1] != a_r[WIDTH-1]);
    assign sh_s      = b_r[SHW-1:0];
    // A guard bit beside the operand catches the last bit shifted out.
    assign shl_s     = {1'b0, a_r} << sh_s;
    assign shr_s     = {a_r, 1'b0} >> sh_s;
    assign sra_s     = $signed({a_r, 1'b0}) >>> sh_s;

    // Single-cycle result and flag selection from the latched operands.
    always_comb begin
        res_s = {WIDTH{1'b0}};
        c_s   = 1'b0;
        v_s   = 1'b0;
        p_s   = 1'b0;
        g_s   = 1'b0;
        case (op_r)
            OP_AND:  res_s = a_r & b_r;
            OP_OR:   res_s = a_r | b_r;
            OP_NOT:  res_s = ~a_r;
            OP_NAND: res_s = ~(a_r & b_r);
            OP_XOR:  res_s = a_r ^ b_r;
            OP_ADD, OP_SUB: begin
                res_s = sum_s[WIDTH-1:0];
                c_s   = sum_s[WIDTH];
                v_s   = ovf_s;
                p_s   = &prop_s;
                g_s   = group_gen(prop_s, gen_s);
            end
            OP_SHL: begin
                res_s = shl_s[WIDTH-1:0];
                c_s   = shl_s[WIDTH];
            end
            OP_SHR: begin
                res_s = shr_s[WIDTH:1];
                c_s   = shr_s[0];
            end
            OP_SRA: begin
                res_s = sra_s[WIDTH:1];
                c_s   = sra_s[0];
            end
            default: res_s = {WIDTH{1'b0}};
        endcase
    end

    // Control FSM, operand latch, multiply datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_IDLE;
            op_r     <= 4'b0000;
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            cin_r    <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            res_r    <= {WIDTH{1'b0}};
            hi_r     <= {WIDTH{1'b0}};
            z_r      <= 1'b0;
            n_r      <= 1'b0;
            c_r      <= 1'b0;
            v_r      <= 1'b0;
            p_r      <= 1'b0;
            g_r      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        op_r     <= bus.seletor;
                        a_r      <= bus.A;
                        b_r      <= bus.B;
                        cin_r    <= bus.cin;
                        busy_r   <= 1'b1;
                        cnt_r    <= {CW{1'b0}};
                        acc_r    <= {(2*WIDTH){1'b0}};
                        mcand_r  <= {{WIDTH{1'b0}}, bus.A};
                        mplier_r <= bus.B;
                        state_r  <= (bus.seletor == OP_MUL) ? S_MUL : S_EXEC;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                S_EXEC: begin
                    res_r   <= res_s;
                    hi_r    <= {WIDTH{1'b0}};
                    z_r     <= (res_s == {WIDTH{1'b0}});
                    n_r     <= res_s[WIDTH-1];
                    c_r     <= c_s;
                    v_r     <= v_s;
                    p_r     <= p_s;
                    g_r     <= g_s;
                    done_r  <= 1'b1;
                    state_r <= S_DONE;
                end
                S_MUL: begin
                    // WIDTH accumulate steps, then one cycle to publish the product.
                    if (cnt_r == CNT_LAST) begin
                        res_r   <= acc_r[WIDTH-1:0];
                        hi_r    <= acc_r[2*WIDTH-1:WIDTH];
                        z_r     <= (acc_r == {(2*WIDTH){1'b0}});
                        n_r     <= acc_r[WIDTH-1];
                        c_r     <= |acc_r[2*WIDTH-1:WIDTH];
                        v_r     <= 1'b0;
                        p_r     <= 1'b0;
                        g_r     <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        if (mplier_r[0]) begin
                            acc_r <= acc_r + mcand_r;
                        end else begin
                            acc_r <= acc_r;
                        end
                        mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
                        mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                        cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.resultado    = res_r;
    assign bus.resultado_hi = hi_r;
    assign bus.Z            = z_r;
    assign bus.N            = n_r;
    assign bus.C            = c_r;
    assign bus.V            = v_r;
    assign bus.P_out        = p_r;
    assign bus.G_out        = g_r;
endmodule
